// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared state encoding and stream format constants for the program loader
//
// Purpose : loader FSM state type and stream framing constants, shared by RTL and bench.
// Contents: state_t (loader states), HDR_BYTES (length header bytes), WORD_BYTES (bytes per word).
package program_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_DATA   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/loader_checksum.sv
// rtl/loader_checksum.sv - 8-bit XOR accumulator over image payload bytes
//
// Purpose : running XOR of payload bytes, cleared at the start of each image.
// Ports   : i_clk   - clock, rising edge
//           i_rst_n - asynchronous active-low reset
//           i_clr   - synchronous clear (wins over i_en)
//           i_en    - fold i_data into the sum this cycle
//           i_data  - payload byte
//           o_sum   - current XOR of all enabled bytes since clear
module loader_checksum (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [7:0] i_data,
  output logic [7:0] o_sum
);

  logic [7:0] r_sum;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sum <= 8'h00;
    end else if (i_clr) begin
      r_sum <= 8'h00;
    end else if (i_en) begin
      r_sum <= r_sum ^ i_data;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream boot loader writing a checksummed image into instruction memory
//
// Purpose : parses LEN_LO, LEN_HI, 4*N payload bytes, CHK; writes each assembled little-endian
//           word to instruction memory, holds the core in reset until the image verifies.
// Ports   : CLK              - clock, rising edge
//           reset            - asynchronous active-low reset
//           rx_valid/rx_data - incoming byte stream; rx_ready accepts it (transfer = valid & ready)
//           mem_write_enable - one-cycle write strobe; mem_address/mem_write_data qualify it
//           core_reset       - active-high core reset, released only on a verified image
//           done / error     - sticky completion / failure flags
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 10,
  parameter int MAX_WORDS     = 2**ADDRESS_WIDTH/4
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  output logic                     rx_ready,
  output logic                     mem_write_enable,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [31:0]              mem_write_data,
  output logic                     core_reset,
  output logic                     done,
  output logic                     error
);

  // Word index covers every word slot plus one guard bit so index+1 == N
  // is representable even for a full-capacity image.
  localparam int IW = ADDRESS_WIDTH - 1;

  state_t          r_state;
  state_t          w_next;
  logic [7:0]      r_len_lo;
  logic [15:0]     r_len;
  logic [IW-1:0]   r_word_idx;
  logic [1:0]      r_byte_cnt;
  logic [31:0]     r_word;

  logic            w_xfer;
  logic [15:0]     w_len;
  logic [IW-1:0]   w_idx_inc;
  logic            w_last_word;
  logic            w_len_too_big;
  logic [7:0]      w_chk;

  assign w_xfer        = rx_valid & rx_ready;
  assign w_len         = {rx_data, r_len_lo};
  assign w_idx_inc     = r_word_idx + IW'(1);
  assign w_last_word   = (32'(w_idx_inc) == 32'(r_len));
  assign w_len_too_big = (int'(w_len) > MAX_WORDS);

  loader_checksum u_checksum (
    .i_clk   (CLK),
    .i_rst_n (reset),
    .i_clr   (w_xfer && (r_state == ST_IDLE)),
    .i_en    (w_xfer && (r_state == ST_DATA)),
    .i_data  (rx_data),
    .o_sum   (w_chk)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_xfer) w_next = ST_LEN_HI;
      ST_LEN_HI: begin
        if (w_xfer) begin
          if (w_len_too_big)     w_next = ST_ERROR;
          else if (w_len == '0)  w_next = ST_CHECK;
          else                   w_next = ST_DATA;
        end
      end
      ST_DATA:   if (w_xfer && (r_byte_cnt == 2'(WORD_BYTES - 1))) w_next = ST_WRITE;
      ST_WRITE:  w_next = w_last_word ? ST_CHECK : ST_DATA;
      ST_CHECK:  if (w_xfer) w_next = (rx_data == w_chk) ? ST_DONE : ST_ERROR;
      ST_DONE:   w_next = ST_DONE;
      ST_ERROR:  w_next = ST_ERROR;
      default:   w_next = ST_IDLE;
    endcase
  end

  // rx_ready is gated by reset directly so it drops the instant reset asserts.
  always_comb begin
    rx_ready         = 1'b0;
    mem_write_enable = 1'b0;
    mem_address      = '0;
    mem_write_data   = '0;
    core_reset       = 1'b1;
    done             = 1'b0;
    error            = 1'b0;
    case (r_state)
      ST_IDLE, ST_LEN_HI, ST_DATA, ST_CHECK: rx_ready = reset;
      ST_WRITE: begin
        mem_write_enable = 1'b1;
        mem_address      = {r_word_idx[IW-2:0], 2'b00};
        mem_write_data   = r_word;
      end
      ST_DONE: begin
        core_reset = 1'b0;
        done       = 1'b1;
      end
      ST_ERROR: error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_len_lo   <= '0;
      r_len      <= '0;
      r_word_idx <= '0;
      r_byte_cnt <= '0;
      r_word     <= '0;
    end else begin
      case (r_state)
        ST_IDLE:   if (w_xfer) r_len_lo <= rx_data;
        ST_LEN_HI: if (w_xfer) r_len <= w_len;
        ST_DATA: begin
          if (w_xfer) begin
            r_word[{r_byte_cnt, 3'b000} +: 8] <= rx_data;
            r_byte_cnt                        <= r_byte_cnt + 2'd1;
          end
        end
        ST_WRITE: begin
          r_word_idx <= w_idx_inc;
          r_word     <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - self-checking bench for program_loader
module tb_program_loader;
  import program_loader_pkg::*;

  localparam int AW   = 10;
  localparam int MAXW = 2**AW/4;

  logic          CLK = 1'b0;
  logic          reset = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready;
  logic          mem_write_enable;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_write_data;
  logic          core_reset;
  logic          done;
  logic          error;

  program_loader #(.ADDRESS_WIDTH(AW)) dut (
    .CLK              (CLK),
    .reset            (reset),
    .rx_valid         (rx_valid),
    .rx_data          (rx_data),
    .rx_ready         (rx_ready),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .core_reset       (core_reset),
    .done             (done),
    .error            (error)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  int          n_writes = 0;
  logic [31:0] last_addr = 0;
  logic [31:0] last_data = 0;

  // Stream-level model: position in the stream decides what each byte means.
  int          m_pos = 0;
  int          m_n = 0;
  int          m_idx = 0;
  int          m_outcome = 0;  // 0 loading, 1 done, 2 error
  logic [7:0]  m_xor = 0;
  logic [31:0] m_word = 0;
  logic [31:0] m_addr = 0;
  logic [31:0] m_data = 0;
  bit          m_wr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_n = 0; m_idx = 0; m_outcome = 0;
    m_xor = 0; m_word = 0; m_wr = 0;
  endtask

  task automatic model_consume(input logic [7:0] b);
    int k;
    if (m_pos == 0) begin
      m_n = int'(b);
    end else if (m_pos == 1) begin
      m_n = m_n + 256 * int'(b);
      if (m_n > MAXW) m_outcome = 2;
    end else if (m_pos < HDR_BYTES + WORD_BYTES * m_n) begin
      k = (m_pos - HDR_BYTES) % WORD_BYTES;
      m_word = m_word | (32'(b) << (8 * k));
      m_xor  = m_xor ^ b;
      if (k == WORD_BYTES - 1) begin
        m_wr   = 1;
        m_addr = 32'(WORD_BYTES * m_idx);
        m_data = m_word;
        m_word = 0;
        m_idx++;
      end
    end else begin
      m_outcome = (b == m_xor) ? 1 : 2;
    end
    m_pos++;
  endtask

  task automatic compare_loop();
    bit exp_ready;
    forever begin
      @(negedge CLK);
      if (!reset) begin
        chk("rst_rx_ready", 32'(rx_ready), 0);
        chk("rst_we", 32'(mem_write_enable), 0);
        chk("rst_addr", 32'(mem_address), 0);
        chk("rst_data", mem_write_data, 0);
        chk("rst_core_reset", 32'(core_reset), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        model_reset();
      end else begin
        exp_ready = (m_outcome == 0) && !m_wr;
        chk("rx_ready", 32'(rx_ready), 32'(exp_ready));
        chk("we", 32'(mem_write_enable), 32'(m_wr));
        if (m_wr) begin
          chk("addr", 32'(mem_address), m_addr);
          chk("wdata", mem_write_data, m_data);
          chk("addr_in_range", 32'(m_addr < 32'(2**AW)), 1);
        end
        chk("done", 32'(done), 32'(m_outcome == 1));
        chk("error", 32'(error), 32'(m_outcome == 2));
        chk("core_reset", 32'(core_reset), 32'(m_outcome != 1));
        if (mem_write_enable) begin
          n_writes++;
          last_addr = 32'(mem_address);
          last_data = mem_write_data;
        end
        m_wr = 0;
        if (rx_valid && exp_ready) model_consume(rx_data);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_idle);
    int guard;
    int idle;
    idle = (max_idle > 0) ? int'($urandom_range(0, max_idle)) : 0;
    rx_valid = 1'b0;
    repeat (idle) @(posedge CLK);
    if (idle > 0) #1;
    rx_valid = 1'b1;
    rx_data  = b;
    guard    = 0;
    forever begin
      @(negedge CLK);
      if (rx_ready) begin
        @(posedge CLK);
        #1;
        rx_valid = 1'b0;
        break;
      end
      guard++;
      if (guard > 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: byte 0x%0h not accepted within 50 cycles", b);
        rx_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic send_stream(input logic [7:0] q[$], input int max_idle);
    foreach (q[i]) send_byte(q[i], max_idle);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] x;
    logic [7:0] b;
    int w0;

    fork
      compare_loop();
    join_none

    // Power-on reset
    repeat (2) @(posedge CLK);
    #1;
    chk("por_rx_ready_low", 32'(rx_ready), 0);
    reset = 1'b1;
    @(negedge CLK);
    chk("por_rx_ready_idle", 32'(rx_ready), 1);
    chk("por_core_reset", 32'(core_reset), 1);
    @(posedge CLK); #1;

    // Single-word image
    w0 = n_writes;
    q = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB6};
    send_stream(q, 0);
    @(negedge CLK);
    chk("one_word_done", 32'(done), 1);
    chk("one_word_core_reset", 32'(core_reset), 0);
    chk("one_word_writes", 32'(n_writes - w0), 1);
    chk("one_word_addr", last_addr, 32'h0);
    chk("one_word_data", last_data, 32'h00A00513);

    // Two words, bad checksum (real XOR is 0x88)
    do_reset();
    w0 = n_writes;
    q = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'hFF};
    send_stream(q, 1);
    @(negedge CLK);
    chk("bad_chk_error", 32'(error), 1);
    chk("bad_chk_core_reset", 32'(core_reset), 1);
    chk("bad_chk_rx_ready", 32'(rx_ready), 0);
    chk("bad_chk_writes", 32'(n_writes - w0), 2);
    chk("bad_chk_last_addr", last_addr, 32'h4);
    chk("bad_chk_last_data", last_data, 32'h88776655);

    // Length 257 exceeds capacity
    do_reset();
    w0 = n_writes;
    q = '{8'h01, 8'h01};
    send_stream(q, 0);
    @(negedge CLK);
    chk("too_long_error", 32'(error), 1);
    chk("too_long_rx_ready", 32'(rx_ready), 0);
    repeat (3) @(negedge CLK);
    chk("too_long_writes", 32'(n_writes - w0), 0);

    // Empty image, good and bad checksum
    do_reset();
    w0 = n_writes;
    q = '{8'h00, 8'h00, 8'h00};
    send_stream(q, 0);
    @(negedge CLK);
    chk("empty_good_done", 32'(done), 1);
    chk("empty_good_writes", 32'(n_writes - w0), 0);
    do_reset();
    q = '{8'h00, 8'h00, 8'h01};
    send_stream(q, 0);
    @(negedge CLK);
    chk("empty_bad_error", 32'(error), 1);

    // Full-capacity image with random stalls
    do_reset();
    w0 = n_writes;
    q = '{8'h00, 8'h01};
    x = 8'h00;
    for (int i = 0; i < 4 * MAXW; i++) begin
      b = 8'($urandom_range(0, 255));
      q.push_back(b);
      x = x ^ b;
    end
    q.push_back(x);
    send_stream(q, 2);
    @(negedge CLK);
    chk("full_done", 32'(done), 1);
    chk("full_writes", 32'(n_writes - w0), 32'(MAXW));
    chk("full_last_addr", last_addr, 32'h3FC);

    // Reset in the middle of a word, then reload
    do_reset();
    w0 = n_writes;
    q = '{8'h01, 8'h00, 8'h13, 8'h05};
    send_stream(q, 0);
    reset = 1'b0;
    #1;
    chk("mid_rst_rx_ready", 32'(rx_ready), 0);
    chk("mid_rst_we", 32'(mem_write_enable), 0);
    chk("mid_rst_core_reset", 32'(core_reset), 1);
    chk("mid_rst_done", 32'(done), 0);
    repeat (2) @(posedge CLK);
    #1;
    reset = 1'b1;
    chk("mid_rst_no_write", 32'(n_writes - w0), 0);
    q = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB6};
    send_stream(q, 1);
    @(negedge CLK);
    chk("reload_done", 32'(done), 1);
    chk("reload_writes", 32'(n_writes - w0), 1);
    chk("reload_addr", last_addr, 32'h0);
    chk("reload_data", last_data, 32'h00A00513);

    repeat (2) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 10, meaning the byte-address width of instruction memory (capacity 2**ADDRESS_WIDTH bytes).
REQ-002 SHALL have parameter MAX_WORDS, default 2**ADDRESS_WIDTH/4, meaning the largest accepted image in 32-bit words.
REQ-003 CLK  input  1  sole clock, rising-edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rx_valid  input  1  byte available on rx_data.
REQ-006 rx_data  input  8  incoming image byte.
REQ-007 rx_ready  output  1  loader accepts byte this cycle; transfer = rx_valid & rx_ready.
REQ-008 mem_write_enable  output  1  one-cycle instruction-memory write strobe.
REQ-009 mem_address  output  ADDRESS_WIDTH  word-aligned byte address of write.
REQ-010 mem_write_data  output  32  word to write.
REQ-011 core_reset  output  1  active-high reset to core; held while loading.
REQ-012 done  output  1  image loaded and checksum good; sticky.
REQ-013 error  output  1  length or checksum failure; sticky.

Function
REQ-014 Stream format SHALL be: LEN_LO, LEN_HI (16-bit word count N, little-endian), 4*N payload bytes (each word little-endian), one CHK byte.
REQ-015 CHK SHALL equal XOR of all 4*N payload bytes; length bytes are excluded.
REQ-016 States SHALL be IDLE (await LEN_LO), LEN_HI, DATA, WRITE, CHECK, DONE, ERROR.
REQ-017 IDLE -> LEN_HI on LEN_LO transfer; LEN_HI -> ERROR if N > MAX_WORDS, CHECK if N == 0, else DATA.
REQ-018 DATA SHALL assemble bytes via a 2-bit byte counter; byte k goes to bits [8k+7:8k]; fourth transfer -> WRITE.
REQ-019 WRITE SHALL last exactly one cycle with mem_write_enable=1, mem_address=4*word_index, mem_write_data=assembled word; rx_ready=0 in WRITE.
REQ-020 After WRITE: word_index increments; -> CHECK if word_index+1 == N, else DATA.
REQ-021 CHECK: on transfer, -> DONE if rx_data == running XOR, else ERROR.
REQ-022 rx_ready SHALL be 1 only in IDLE, LEN_HI, DATA, CHECK.
REQ-023 DONE: core_reset=0, done=1, rx_ready=0; remains until reset.
REQ-024 ERROR: core_reset=1, error=1, rx_ready=0; remains until reset; no further memory writes.
REQ-025 rx_valid low SHALL stall any state without timeout; no byte may be lost or duplicated.
REQ-026 mem_address SHALL never reach or exceed 2**ADDRESS_WIDTH; word_index width = ADDRESS_WIDTH-2 bits plus 1 guard bit.
REQ-027 Byte latency: write strobe SHALL occur the cycle after the fourth byte of a word transfers.

Reset
REQ-028 On reset low, state=IDLE, word_index=0, byte counter=0, checksum=0, word buffer=0, immediately and asynchronously.
REQ-029 Reset outputs: rx_ready=0 while reset low, 1 in IDLE after release; mem_write_enable=0, mem_address=0, mem_write_data=0, core_reset=1, done=0, error=0.
REQ-030 Reset asserted mid-load SHALL abort with no further writes; partial image in memory is not cleared.

Structure
REQ-031 State encoding and the format constants (header byte count 2, word bytes 4) SHALL live in a shared package used by loader and bench.
REQ-032 A single sub-module, loader_checksum (8-bit XOR accumulator with clear and enable), is natural; all else flat.

Verification
REQ-033 Stream 01 00 13 05 A0 00 B6 -> one write addr 0x000 data 0x00A00513, done=1, core_reset=0 the cycle after CHK.
REQ-034 Stream 02 00 + two words + bad CHK 0xFF -> two writes (0x000, 0x004), then error=1, core_reset stays 1, rx_ready=0.
REQ-035 N=0x0101 (257 > MAX_WORDS 256) -> error=1 after LEN_HI, zero writes.
REQ-036 N=0, CHK 0x00 -> done=1, zero writes; CHK 0x01 -> error=1.
REQ-037 N=256 with rx_valid toggled randomly -> 256 writes at 0x000..0x3FC, order and data exact, no address wrap, done=1.
REQ-038 Assert reset low mid-word (after 2 payload bytes) -> outputs at reset values same cycle; new stream 01 00 ... loads to address 0x000 correctly.
